// File: rtl/reg_writeback_queue.sv
// In-order writeback queue feeding the register file's single write port; r15 goes to the PC.
// Optional pending-destination scoreboard on `busy` is built when WBQ_SCOREBOARD_EN is defined.
module reg_writeback_queue #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    ex_valid,
   output logic                    ex_ready,
   input  logic [ADDR_W-1:0]       ex_addr,
   input  logic [DATA_W-1:0]       ex_data,
   input  logic                    mem_valid,
   output logic                    mem_ready,
   input  logic [ADDR_W-1:0]       mem_addr,
   input  logic [DATA_W-1:0]       mem_data,
   output logic                    we3,
   output logic [ADDR_W-1:0]       ra3,
   output logic [DATA_W-1:0]       wd3,
   output logic                    pc_we,
   output logic [DATA_W-1:0]       pc_wd,
   output logic [2**ADDR_W-1:0]    busy,
   output logic [$clog2(DEPTH):0]  count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam logic [PW:0] CntLeM1 = (PW+1)'(DEPTH - 1);
   localparam logic [PW:0] CntLeM2 = (PW+1)'(DEPTH - 2);
   localparam logic [ADDR_W-1:0] PcAddr = ADDR_W'(15);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic [PW:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0] count_q, count_d;

   logic [PW-1:0] rd_idx;
   logic [PW-1:0] wr_idx;
   logic [PW-1:0] ex_idx;
   logic          empty;
   logic          full;
   logic          pop;
   logic          mem_push;
   logic          ex_push;
   logic [ADDR_W-1:0] head_addr;
   logic [DATA_W-1:0] head_data;
   logic          head_is_pc;

   assign rd_idx = rd_ptr_q[PW-1:0];
   assign wr_idx = wr_ptr_q[PW-1:0];
   assign empty  = (rd_ptr_q == wr_ptr_q);
   assign full   = (rd_idx == wr_idx) && (rd_ptr_q[PW] != wr_ptr_q[PW]);
   assign pop    = !empty;

   // Ready looks only at the registered occupancy, never at this cycle's pop.
   always_comb begin
      mem_ready = 1'b0;
      ex_ready  = 1'b0;
      if (!reset) begin
         mem_ready = (count_q <= CntLeM1);
         ex_ready  = mem_valid ? (count_q <= CntLeM2) : (count_q <= CntLeM1);
      end
   end

   assign mem_push = mem_valid && mem_ready;
   assign ex_push  = ex_valid && ex_ready;
   // The load is older, so it takes the first free slot when both arrive together.
   assign ex_idx   = wr_idx + PW'(mem_push);

   always_comb begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         addr_d[i] = addr_q[i];
         data_d[i] = data_q[i];
      end
      if (mem_push) begin
         addr_d[wr_idx] = mem_addr;
         data_d[wr_idx] = mem_data;
      end
      if (ex_push) begin
         addr_d[ex_idx] = ex_addr;
         data_d[ex_idx] = ex_data;
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(mem_push) + (PW+1)'(ex_push);
      rd_ptr_d = rd_ptr_q + (PW+1)'(pop);
      count_d  = count_q + (PW+1)'(mem_push) + (PW+1)'(ex_push) - (PW+1)'(pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; validity comes from the pointers.
   always_ff @(posedge clk) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
         addr_q[i] <= addr_d[i];
         data_q[i] <= data_d[i];
      end
   end

   assign head_addr  = addr_q[rd_idx];
   assign head_data  = data_q[rd_idx];
   assign head_is_pc = (head_addr == PcAddr);

   always_comb begin
      we3   = 1'b0;
      ra3   = '0;
      wd3   = '0;
      pc_we = 1'b0;
      pc_wd = '0;
      if (!reset && !empty) begin
         if (head_is_pc) begin
            pc_we = 1'b1;
            pc_wd = head_data;
         end else begin
            we3 = 1'b1;
            ra3 = head_addr;
            wd3 = head_data;
         end
      end
   end

   assign count = count_q;

`ifdef WBQ_SCOREBOARD_EN
   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      logic [PW-1:0] off;
      busy = '0;
      off  = '0;
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            off = PW'(i) - rd_idx;
            if ({1'b0, off} < count_q) begin
               busy[addr_q[i]] = 1'b1;
            end
         end
      end
   end
`else
   assign busy = '0;
`endif

   a_count_ptrs : assert property (@(posedge clk) disable iff (reset)
      count_q == (wr_ptr_q - rd_ptr_q));
   a_full_count : assert property (@(posedge clk) disable iff (reset)
      full == (count_q == (PW+1)'(DEPTH)));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed, table-driven bench for reg_writeback_queue (DEPTH=4, DATA_W=32, ADDR_W=4).
// Busy expectations apply only when WBQ_SCOREBOARD_EN is defined; otherwise busy must be 0.
module tb_reg_writeback_queue;

   logic        clk;
   logic        reset;
   logic        ex_valid;
   logic        ex_ready;
   logic [3:0]  ex_addr;
   logic [31:0] ex_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [3:0]  mem_addr;
   logic [31:0] mem_data;
   logic        we3;
   logic [3:0]  ra3;
   logic [31:0] wd3;
   logic        pc_we;
   logic [31:0] pc_wd;
   logic [15:0] busy;
   logic [2:0]  count;

   int n_checks;
   int n_fail;

   reg_writeback_queue #(
      .DEPTH (4),
      .DATA_W(32),
      .ADDR_W(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ex_valid (ex_valid),
      .ex_ready (ex_ready),
      .ex_addr  (ex_addr),
      .ex_data  (ex_data),
      .mem_valid(mem_valid),
      .mem_ready(mem_ready),
      .mem_addr (mem_addr),
      .mem_data (mem_data),
      .we3      (we3),
      .ra3      (ra3),
      .wd3      (wd3),
      .pc_we    (pc_we),
      .pc_wd    (pc_wd),
      .busy     (busy),
      .count    (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        ex_v;
      logic [3:0]  ex_a;
      logic [31:0] ex_d;
      logic        m_v;
      logic [3:0]  m_a;
      logic [31:0] m_d;
      logic        we3;
      logic [3:0]  ra3;
      logic [31:0] wd3;
      logic        pc_we;
      logic [31:0] pc_wd;
      logic        ex_rdy;
      logic        m_rdy;
      logic [2:0]  cnt;
      logic [15:0] busy;
   } vec_t;

   vec_t vq[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] exp_busy(input logic [15:0] b);
`ifdef WBQ_SCOREBOARD_EN
      return b;
`else
      return 16'h0000 & b;
`endif
   endfunction

   task automatic drive(input logic exv, input logic [3:0] exa, input logic [31:0] exd,
                        input logic mv, input logic [3:0] ma, input logic [31:0] md);
      ex_valid  = exv;
      ex_addr   = exa;
      ex_data   = exd;
      mem_valid = mv;
      mem_addr  = ma;
      mem_data  = md;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic exv, input logic [3:0] exa, input logic [31:0] exd,
                      input logic mv, input logic [3:0] ma, input logic [31:0] md,
                      input logic w, input logic [3:0] ra, input logic [31:0] wd,
                      input logic pw, input logic [31:0] pd, input logic er,
                      input logic mr, input logic [2:0] c, input logic [15:0] b);
      vec_t v;
      v.ex_v = exv; v.ex_a = exa; v.ex_d = exd;
      v.m_v = mv; v.m_a = ma; v.m_d = md;
      v.we3 = w; v.ra3 = ra; v.wd3 = wd; v.pc_we = pw; v.pc_wd = pd;
      v.ex_rdy = er; v.m_rdy = mr; v.cnt = c; v.busy = b;
      vq.push_back(v);
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_fail   = 0;

      // Inputs           | expected outputs during the same cycle
      //   exv exa exd        mv ma md      we3 ra3 wd3          pcwe pcwd   exr mr cnt busy
      add(0, 0, 0,            0, 0, 0,       0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      add(1, 3, 32'hDEADBEEF, 0, 0, 0,       0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      add(0, 0, 0,            0, 0, 0,       1, 3, 32'hDEADBEEF, 0, 0,      1, 1, 1, 16'h0008);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      // Dual accept to r5: mem 0x11 must land before ex 0x22.
      add(1, 5, 32'h22,       1, 5, 32'h11,  0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      add(0, 0, 0,            0, 0, 0,       1, 5, 32'h11,       0, 0,      1, 1, 2, 16'h0020);
      add(0, 0, 0,            0, 0, 0,       1, 5, 32'h22,       0, 0,      1, 1, 1, 16'h0020);
      // PC diversion.
      add(1, 15, 32'h100,     0, 0, 0,       0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0,            1, 32'h100, 1, 1, 1, 16'h8000);
      // Fill: both valid for three cycles; ex 7 is refused at count 3.
      add(1, 2, 32'hA2,       1, 1, 32'hA1,  0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);
      add(1, 4, 32'hA4,       1, 3, 32'hA3,  1, 1, 32'hA1,       0, 0,      1, 1, 2, 16'h0006);
      add(1, 7, 32'hA7,       1, 6, 32'hA6,  1, 2, 32'hA2,       0, 0,      0, 1, 3, 16'h001C);
      add(0, 0, 0,            0, 0, 0,       1, 3, 32'hA3,       0, 0,      1, 1, 3, 16'h0058);
      add(0, 0, 0,            0, 0, 0,       1, 4, 32'hA4,       0, 0,      1, 1, 2, 16'h0050);
      add(0, 0, 0,            0, 0, 0,       1, 6, 32'hA6,       0, 0,      1, 1, 1, 16'h0040);
      add(0, 0, 0,            0, 0, 0,       0, 0, 0,            0, 0,      1, 1, 0, 16'h0000);

      // Reset with requests pending: nothing may be accepted or written.
      reset = 1'b1;
      drive(1, 4'd9, 32'h99, 1, 4'd8, 32'h88);
      next_cycle();
      next_cycle();
      #1;
      chk("rst.we3", 32'(we3), 0);
      chk("rst.pc_we", 32'(pc_we), 0);
      chk("rst.ex_ready", 32'(ex_ready), 0);
      chk("rst.mem_ready", 32'(mem_ready), 0);
      chk("rst.busy", 32'(busy), 0);
      chk("rst.count", 32'(count), 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         v = vq[i];
         drive(v.ex_v, v.ex_a, v.ex_d, v.m_v, v.m_a, v.m_d);
         #2;
         chk($sformatf("v%0d.we3", i), 32'(we3), 32'(v.we3));
         chk($sformatf("v%0d.ra3", i), 32'(ra3), 32'(v.ra3));
         chk($sformatf("v%0d.wd3", i), wd3, v.wd3);
         chk($sformatf("v%0d.pc_we", i), 32'(pc_we), 32'(v.pc_we));
         chk($sformatf("v%0d.pc_wd", i), pc_wd, v.pc_wd);
         chk($sformatf("v%0d.ex_ready", i), 32'(ex_ready), 32'(v.ex_rdy));
         chk($sformatf("v%0d.mem_ready", i), 32'(mem_ready), 32'(v.m_rdy));
         chk($sformatf("v%0d.count", i), 32'(count), 32'(v.cnt));
         chk($sformatf("v%0d.busy", i), 32'(busy), 32'(exp_busy(v.busy)));
         next_cycle();
      end

      // Mid-operation reset: three entries queued, then a one-cycle reset.
      drive(1, 4'd9, 32'hB9, 1, 4'd8, 32'hB8);
      next_cycle();
      drive(1, 4'd11, 32'hBB, 1, 4'd10, 32'hBA);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("mid.count_before", 32'(count), 3);
      chk("mid.busy_before", 32'(busy), 32'(exp_busy(16'h0E00)));
      reset = 1'b1;
      #1;
      chk("mid.rst_we3", 32'(we3), 0);
      chk("mid.rst_ready", 32'({ex_ready, mem_ready}), 0);
      chk("mid.rst_busy", 32'(busy), 0);
      next_cycle();
      reset = 1'b0;
      #1;
      chk("mid.post_we3", 32'(we3), 0);
      chk("mid.post_pc_we", 32'(pc_we), 0);
      chk("mid.post_count", 32'(count), 0);
      chk("mid.post_busy", 32'(busy), 0);
      chk("mid.post_ready", 32'({ex_ready, mem_ready}), 3);
      drive(1, 4'd12, 32'hC12, 0, 0, 0);
      next_cycle();
      drive(0, 0, 0, 0, 0, 0);
      #1;
      chk("mid.after_we3", 32'(we3), 1);
      chk("mid.after_ra3", 32'(ra3), 12);
      chk("mid.after_wd3", wd3, 32'hC12);
      next_cycle();
      #1;
      chk("mid.drain_we3", 32'(we3), 0);
      chk("mid.drain_count", 32'(count), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/reg_writeback_queue.md
# reg_writeback_queue

Write-side front end for the processor register file. Accepts register-writeback requests from the execute path and the memory-load path through valid/ready handshakes, buffers them in a small in-order queue, and drives the register file's single write port (`we3`, `ra3`, `wd3`) at one write per cycle. Writes addressed to register 15 are diverted to a PC-write output, because register 15 is not stored in the file. A per-register pending scoreboard lets decode stall on outstanding destinations.

## Interface
Parameters:
- `DEPTH`, 4, queue entries (power of two, ≥2)
- `DATA_W`, 32, writeback data width
- `ADDR_W`, 4, register address width (16 architectural registers)

Ports:
- `clk` in 1: single clock; all state updates on the rising edge
- `reset` in 1: synchronous, active-high
- `ex_valid` in 1: execute writeback request
- `ex_ready` out 1: execute request accepted this cycle when high with `ex_valid`
- `ex_addr` in ADDR_W: execute destination register
- `ex_data` in DATA_W: execute result
- `mem_valid` in 1: load writeback request
- `mem_ready` out 1: load request accepted this cycle when high with `mem_valid`
- `mem_addr` in ADDR_W: load destination register
- `mem_data` in DATA_W: load data
- `we3` out 1: register-file write enable
- `ra3` out ADDR_W: register-file write address
- `wd3` out DATA_W: register-file write data
- `pc_we` out 1: PC write strobe for destination 15
- `pc_wd` out DATA_W: PC write value
- `busy` out 2^ADDR_W: pending-destination bitmap (see Configuration)
- `count` out log2(DEPTH)+1: current queue occupancy

## Operation
- Circular queue of {addr, data}. Read and write pointers carry one extra wrap bit; full means the pointers are equal except for the wrap bit; empty means they are fully equal.
- Pop: every cycle the queue is non-empty, the head entry is presented and popped at the next edge. The pop is unconditional, with no backpressure from the register file.
- Head addr ≠ 15: `we3`=1, `ra3`/`wd3`=head, `pc_we`=0. Head addr = 15: `pc_we`=1, `pc_wd`=head data, `we3`=0.
- Empty: `we3`=0, `pc_we`=0, `ra3`/`wd3`/`pc_wd` hold 0.
- Ready depends only on registered `count`, not on this cycle's pop:
  - `mem_ready` = (`count` ≤ DEPTH−1).
  - `ex_ready` = (`count` ≤ DEPTH−2) when `mem_valid`, else (`count` ≤ DEPTH−1).
- Both requests accepted in the same cycle: the mem entry is enqueued first, then ex. The mem path has priority because its instruction is older.
- Ordering: strict FIFO. Two entries to the same register are written in enqueue order, so the later one wins.
- `count` next value = `count` + pushes (0–2) − pop (0–1).
- Reset: pointers and `count` cleared, so all queued entries are discarded. `we3`, `pc_we`, `ex_ready`, `mem_ready`, and `busy` are 0 while `reset` is high. Ready goes high the first cycle after `reset` falls.

## Timing
- Latency: a request accepted at edge E drives `we3` or `pc_we` during cycle E→E+1, provided the queue was empty before E.
- Each entry drives exactly one write cycle.
- The register file commits on the falling edge inside that cycle. The read ports therefore see the new value from the second half of the write cycle.
- Throughput: 1 write per cycle sustained. Bursts of 2 per cycle are absorbed up to DEPTH.
- Full plus simultaneous pop: ready stays low that cycle (conservative), and reasserts the following cycle.
- `reset` asserted mid-burst: outputs go to 0 at the next edge, and no partial write is emitted after that edge.

## Configuration
- `WBQ_SCOREBOARD_EN` defined:
  - `busy[r]`=1 iff any valid queue entry has addr r, evaluated combinationally from queue contents and pointers.
  - `busy[15]` tracks pending PC writes.
  - An entry's bit clears in the cycle after its pop, unless another entry with the same address remains queued.
- Not defined: `busy` is tied to 0 and no scoreboard logic is built.

## Test plan
- Single write: after reset, `ex_valid`=1, addr 3, data 0xDEADBEEF for one cycle. Required: next cycle `we3`=1, `ra3`=3, `wd3`=0xDEADBEEF; following cycle `we3`=0 and `count`=0.
- Dual accept ordering: `mem` addr 5 = 0x11 and `ex` addr 5 = 0x22 in the same cycle. Required: two consecutive writes to r5, first 0x11 then 0x22. With `WBQ_SCOREBOARD_EN`, `busy[5]`=1 for two cycles.
- PC diversion: `ex` addr 15, data 0x100. Required: `pc_we`=1, `pc_wd`=0x100, and `we3`=0 in that cycle.
- Fill/backpressure, DEPTH=4: hold both valids high for 3 cycles. Required:
  - `count` sequence 0→2→3→3.
  - `ex_ready` low once `count`≥3 with `mem_valid` high.
  - `mem_ready` low only at `count`=4.
  - Total writes equal total accepts, in order.
- Reset mid-operation: queue 3 entries, then assert `reset` for 1 cycle. Required: no `we3`/`pc_we` after the reset edge, `count`=0, `busy`=0, and ready high one cycle after `reset` deasserts.
